ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the number of TX FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter INHIBIT_TICKS, default 16'd240, the clock-low inhibit time in peripheral ticks.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 16'd4000, the maximum peripheral ticks per frame after inhibit.
REQ-004 SHALL have port clock, input, 1 bit: system clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port peripheral_clock, input, 1 bit: slow tick source; only its rising edge, 2-FF synchronized, counts as a tick.
REQ-007 SHALL have port device_clock, input, 1 bit: sampled PS/2 clock line.
REQ-008 SHALL have port device_data, input, 1 bit: sampled PS/2 data line.
REQ-009 SHALL have port device_clock_out, output, 1 bit: 0 pulls the clock line low, 1 releases it.
REQ-010 SHALL have port device_data_out, output, 1 bit: 0 pulls the data line low, 1 releases it.
REQ-011 SHALL have port tx_valid, input, 1 bit: a byte is offered.
REQ-012 SHALL have port tx_ready, output, 1 bit: the FIFO is not full.
REQ-013 SHALL have port tx_data, input, 8 bits: the byte to send.
REQ-014 SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-015 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes successfully.
REQ-017 SHALL have port error, output, 1 bit: one-cycle pulse when a frame fails (timeout, or NACK when enabled).

Function
REQ-018 A byte SHALL be written into the FIFO when tx_valid and tx_ready are both high in the same cycle.
REQ-019 A write while the FIFO is full SHALL be dropped; a simultaneous write and pop SHALL leave fifo_level unchanged.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH; tx_ready SHALL equal (fifo_level != FIFO_DEPTH).
REQ-021 The frame format SHALL be start 0, data bits 0..7 LSB first, odd parity, stop 1, then the device ACK bit.
REQ-022 The FSM states SHALL be IDLE, INHIBIT, REQUEST, SHIFT, ACK, RELEASE.
REQ-023 IDLE: when the FIFO is non-empty, the FSM SHALL pop the head into a 10-bit shift register {stop, parity, data} and go to INHIBIT on the next cycle.
REQ-024 INHIBIT: clock_out=0 and data_out=1; the FSM SHALL go to REQUEST after INHIBIT_TICKS ticks.
REQ-025 REQUEST: clock_out=0 and data_out=0 (start bit) for 1 tick, then the clock SHALL be released and the FSM SHALL go to SHIFT.
REQ-026 SHIFT: on each device_clock falling edge (prev=1, now=0), data_out SHALL take shift[0], the register shifts right with 1 fill, and the bit count increments.
REQ-027 SHIFT: after the 10th falling edge the FSM SHALL go to ACK with data_out=1.
REQ-028 ACK: on the next falling edge, device_data SHALL be sampled as the ack bit and the FSM SHALL go to RELEASE.
REQ-029 RELEASE: when device_clock is high and device_data is high, the FSM SHALL pulse done (or error on NACK) and go to IDLE.
REQ-030 The tick counter SHALL clear on every state change.
REQ-031 A separate frame counter SHALL count ticks from REQUEST onward.
REQ-032 If the frame counter reaches TIMEOUT_TICKS in any non-IDLE state, the FSM SHALL pulse error, release both lines, and return to IDLE.
REQ-033 On timeout, the FIFO byte SHALL stay consumed; no automatic retry SHALL occur.
REQ-034 A new FIFO entry SHALL NOT be popped in the same cycle that done or error pulses.
REQ-035 Outputs device_clock_out and device_data_out SHALL be registered.

Reset
REQ-036 On reset: state=IDLE, FIFO empty, fifo_level=0, tx_ready=1, busy=0, done=0, error=0, device_clock_out=1, device_data_out=1, all counters 0, shift register all 1s.
REQ-037 Reset asserted mid-frame SHALL release both lines immediately and discard all queued bytes.

Configuration
REQ-038 Macro PS2_HOST_TX_ACK_CHECK_EN, when defined: a sampled ack of 1 SHALL produce error instead of done.
REQ-039 When PS2_HOST_TX_ACK_CHECK_EN is undefined: the ack bit SHALL be ignored and every non-timeout frame SHALL produce done.

Structure
REQ-040 Package ps2_host_pkg SHALL hold the ps2_tx_state_t enum, PS2_FRAME_BITS=10, and the odd-parity function.
REQ-041 The FIFO SHALL be the sub-module ps2_tx_fifo (parameter DEPTH, width 8, push/pop/level).

Verification
REQ-042 Write 8'hED, device ack 0 -> bits after start SHALL be 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; error stays 0.
REQ-043 Write 8'h00 -> parity bit SHALL be 1; write 8'h01 -> parity bit SHALL be 0.
REQ-044 Write 5 bytes with FIFO_DEPTH=4 and no device clock -> 5th write SHALL be refused (tx_ready=0) and fifo_level SHALL be 4.
REQ-045 Never toggle device_clock after REQUEST -> error SHALL pulse after TIMEOUT_TICKS ticks, lines SHALL be released, and the next byte SHALL start.
REQ-046 Device ack 1 -> error pulse with PS2_HOST_TX_ACK_CHECK_EN defined, done pulse without it.
REQ-047 Assert reset during SHIFT at bit 4 -> both outputs SHALL be 1 at once, and fifo_level=0 and busy=0 after reset.

Source files
------------

// File: rtl/ps2_host_pkg.sv
// Shared types and helpers for the PS/2 host transmitter: FSM state encoding,
// frame length and the odd-parity generator.
package ps2_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SHIFT,
        ACK,
        RELEASE
    } ps2_tx_state_t;

    // Bits the host drives after the start bit: 8 data, parity, stop.
    localparam int PS2_FRAME_BITS = 10;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO feeding the PS/2 transmitter; show-ahead head output, drops pushes
// while full and ignores pops while empty.
module ps2_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [7:0]               i_push_data,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter with TX FIFO, inhibit/request sequencing
// and frame timeout. Define PS2_HOST_TX_ACK_CHECK_EN to turn a NACK into error.
module ps2_host_tx
    import ps2_host_pkg::*;
#(
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [15:0] INHIBIT_TICKS = 16'd240,
    parameter logic [15:0] TIMEOUT_TICKS = 16'd4000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          peripheral_clock,
    input  logic                          device_clock,
    input  logic                          device_data,
    output logic                          device_clock_out,
    output logic                          device_data_out,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [7:0]                    tx_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          done,
    output logic                          error
);

    ps2_tx_state_t             r_state;
    ps2_tx_state_t             w_state_next;
    logic [2:0]                r_pclk_sync;
    logic                      r_dclk_prev;
    logic [15:0]               r_tick_cnt;
    logic [15:0]               r_frame_cnt;
    logic [3:0]                r_bit_cnt;
    logic [3:0]                w_bit_cnt_next;
    logic [PS2_FRAME_BITS-1:0] r_shift;
    logic [PS2_FRAME_BITS-1:0] w_shift_next;
    logic                      r_clk_out;
    logic                      w_clk_out_next;
    logic                      r_data_out;
    logic                      w_data_out_next;
    logic                      r_done;
    logic                      w_done_next;
    logic                      r_error;
    logic                      w_error_next;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
    logic                      r_ack;
    logic                      w_ack_next;
`endif
    logic                      w_tick;
    logic                      w_dclk_fall;
    logic                      w_timeout;
    logic                      w_frame_active;
    logic                      w_pop;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [7:0]                w_head;

    ps2_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (tx_valid),
        .i_push_data (tx_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_level     (fifo_level),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign tx_ready         = !w_fifo_full;
    assign busy             = (r_state != IDLE) || !w_fifo_empty;
    assign done             = r_done;
    assign error            = r_error;
    assign device_clock_out = r_clk_out;
    assign device_data_out  = r_data_out;

    assign w_tick         = r_pclk_sync[1] & ~r_pclk_sync[2];
    assign w_dclk_fall    = r_dclk_prev & ~device_clock;
    assign w_frame_active = (r_state == REQUEST) || (r_state == SHIFT) ||
                            (r_state == ACK) || (r_state == RELEASE);
    assign w_timeout      = (r_state != IDLE) && (r_frame_cnt >= TIMEOUT_TICKS);

    // Peripheral tick: 2-FF synchronizer plus one stage for rising-edge detect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pclk_sync <= '0;
            r_dclk_prev <= 1'b1;
        end else begin
            r_pclk_sync <= {r_pclk_sync[1:0], peripheral_clock};
            r_dclk_prev <= device_clock;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_frame_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '1;
            r_clk_out  <= 1'b1;
            r_data_out <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
            r_ack      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_clk_out  <= w_clk_out_next;
            r_data_out <= w_data_out_next;
            r_done     <= w_done_next;
            r_error    <= w_error_next;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
            r_ack      <= w_ack_next;
`endif
            if (w_state_next != r_state) begin
                r_tick_cnt <= '0;
            end else if (w_tick && (r_state != IDLE)) begin
                r_tick_cnt <= r_tick_cnt + 16'd1;
            end
            if (w_state_next == IDLE) begin
                r_frame_cnt <= '0;
            end else if (w_tick && w_frame_active) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pop           = 1'b0;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_clk_out_next  = r_clk_out;
        w_data_out_next = r_data_out;
        w_done_next     = 1'b0;
        w_error_next    = 1'b0;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
        w_ack_next      = r_ack;
`endif
        if (w_timeout) begin
            // Abandon the frame; the popped byte is not retried.
            w_state_next    = IDLE;
            w_clk_out_next  = 1'b1;
            w_data_out_next = 1'b1;
            w_error_next    = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_clk_out_next  = 1'b1;
                    w_data_out_next = 1'b1;
                    // Hold off one cycle while a completion pulse is visible.
                    if (!w_fifo_empty && !r_done && !r_error) begin
                        w_pop           = 1'b1;
                        w_shift_next    = {1'b1, odd_parity(w_head), w_head};
                        w_bit_cnt_next  = '0;
                        w_state_next    = INHIBIT;
                        w_clk_out_next  = 1'b0;
                        w_data_out_next = 1'b1;
                    end
                end
                INHIBIT: begin
                    if (w_tick && (({1'b0, r_tick_cnt} + 17'd1) >= {1'b0, INHIBIT_TICKS})) begin
                        w_state_next    = REQUEST;
                        w_clk_out_next  = 1'b0;
                        w_data_out_next = 1'b0;
                    end
                end
                REQUEST: begin
                    if (w_tick) begin
                        w_state_next   = SHIFT;
                        w_clk_out_next = 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_dclk_fall) begin
                        w_data_out_next = r_shift[0];
                        w_shift_next    = {1'b1, r_shift[PS2_FRAME_BITS-1:1]};
                        w_bit_cnt_next  = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'(PS2_FRAME_BITS - 1)) begin
                            w_state_next    = ACK;
                            w_data_out_next = 1'b1;
                        end
                    end
                end
                ACK: begin
                    w_data_out_next = 1'b1;
                    if (w_dclk_fall) begin
`ifdef PS2_HOST_TX_ACK_CHECK_EN
                        w_ack_next   = device_data;
`endif
                        w_state_next = RELEASE;
                    end
                end
                RELEASE: begin
                    if (device_clock && device_data) begin
`ifdef PS2_HOST_TX_ACK_CHECK_EN
                        w_done_next  = !r_ack;
                        w_error_next = r_ack;
`else
                        w_done_next  = 1'b1;
`endif
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next    = IDLE;
                    w_clk_out_next  = 1'b1;
                    w_data_out_next = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: acts as the PS/2 device, clocks frames out,
// and checks bits, completion pulses, FIFO limits, timeout and mid-frame reset.
module tb_ps2_host_tx;

    localparam int          DEPTH = 4;
    localparam logic [15:0] INH   = 16'd4;
    localparam logic [15:0] TMO   = 16'd60;

    logic                   clock            = 1'b0;
    logic                   reset            = 1'b1;
    logic                   peripheral_clock = 1'b0;
    logic                   device_clock     = 1'b1;
    logic                   device_data      = 1'b1;
    logic                   tx_valid         = 1'b0;
    logic [7:0]             tx_data          = 8'h00;
    logic                   device_clock_out;
    logic                   device_data_out;
    logic                   tx_ready;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   done;
    logic                   error;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    ps2_host_tx #(
        .FIFO_DEPTH    (DEPTH),
        .INHIBIT_TICKS (INH),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .peripheral_clock (peripheral_clock),
        .device_clock     (device_clock),
        .device_data      (device_data),
        .device_clock_out (device_clock_out),
        .device_data_out  (device_data_out),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_data          (tx_data),
        .busy             (busy),
        .fifo_level       (fifo_level),
        .done             (done),
        .error            (error)
    );

    always #5 clock = ~clock;

    // One peripheral tick every 8 system clocks.
    initial begin
        forever begin
            repeat (4) @(posedge clock);
            peripheral_clock = ~peripheral_clock;
        end
    end

    always @(negedge clock) begin
        if (done)  done_cnt++;
        if (error) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    task automatic dev_bit(input logic drive_data, output logic sampled);
        device_data  = drive_data;
        device_clock = 1'b0;
        repeat (4) @(negedge clock);
        sampled      = device_data_out;
        device_clock = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic wait_inhibit(input string tag);
        for (int k = 0; k < 200 && !(device_clock_out === 1'b0 && device_data_out === 1'b1); k++)
            @(negedge clock);
        check(tag, {device_clock_out, device_data_out}, 2'b01);
    endtask

    task automatic wait_request(input string tag);
        for (int k = 0; k < 100 && !(device_clock_out === 1'b0 && device_data_out === 1'b0); k++)
            @(negedge clock);
        check(tag, {device_clock_out, device_data_out}, 2'b00);
    endtask

    task automatic run_frame(input logic ack, output logic [9:0] bits, output int inh_cyc);
        logic s;
        wait_inhibit("inhibit_lines");
        inh_cyc = 0;
        while (inh_cyc < 100 && device_clock_out === 1'b0 && device_data_out === 1'b1) begin
            @(negedge clock);
            inh_cyc++;
        end
        check("request_lines", {device_clock_out, device_data_out}, 2'b00);
        for (int k = 0; k < 20 && device_clock_out === 1'b0; k++) @(negedge clock);
        check("start_bit_held", {device_clock_out, device_data_out}, 2'b10);
        for (int i = 0; i < 10; i++) begin
            dev_bit(1'b1, s);
            bits[i] = s;
        end
        dev_bit(ack, s);
        device_data = 1'b1;
    endtask

    task automatic wait_result(input int prev_sum);
        for (int k = 0; k < 50 && (done_cnt + err_cnt) == prev_sum; k++) @(negedge clock);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        logic [9:0] bits;
        logic [7:0] burst [5];
        int         inh;
        int         t;
        int         sum0;
        int         d0;
        int         e0;
        int         exp_done;
        int         exp_err;

        burst = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        repeat (3) @(negedge clock);
        check("rst_clock_out", device_clock_out, 1'b1);
        check("rst_data_out", device_data_out, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_level", fifo_level, 0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        sum0 = done_cnt + err_cnt;
        push(8'hED);
        check("level_after_push", fifo_level, 1);
        check("busy_after_push", busy, 1'b1);
        run_frame(1'b0, bits, inh);
        $display("frame data=ed bits=%03h inhibit_cycles=%0d", bits, inh);
        check("bits_ed", bits, 10'h3ED);
        check("inhibit_len_in_range", (inh >= 24 && inh <= 34), 1'b1);
        wait_result(sum0);
        check("done_count_ed", done_cnt, 1);
        check("error_count_ed", err_cnt, 0);
        check("lines_idle_ed", {device_clock_out, device_data_out}, 2'b11);
        check("busy_idle_ed", busy, 1'b0);

        sum0 = done_cnt + err_cnt;
        push(8'h00);
        push(8'h01);
        check("level_push_with_pop", fifo_level, 1);
        run_frame(1'b0, bits, inh);
        $display("frame data=00 bits=%03h", bits);
        check("bits_00_parity1", bits, 10'h300);
        run_frame(1'b0, bits, inh);
        $display("frame data=01 bits=%03h", bits);
        check("bits_01_parity0", bits, 10'h201);
        wait_result(sum0 + 1);
        check("done_count_00_01", done_cnt, 3);

`ifdef PS2_HOST_TX_ACK_CHECK_EN
        exp_done = 3;
        exp_err  = 1;
`else
        exp_done = 4;
        exp_err  = 0;
`endif
        sum0 = done_cnt + err_cnt;
        push(8'hA5);
        run_frame(1'b1, bits, inh);
        $display("frame data=a5 ack=1 bits=%03h", bits);
        check("bits_a5", bits, 10'h3A5);
        wait_result(sum0);
        check("nack_done_count", done_cnt, exp_done);
        check("nack_error_count", err_cnt, exp_err);

        push(8'h11);
        wait_inhibit("inhibit_11");
        for (int i = 0; i < 5; i++) begin
            tx_data  = burst[i];
            tx_valid = 1'b1;
            if (i == 4) check("ready_low_on_5th", tx_ready, 1'b0);
            @(negedge clock);
        end
        tx_valid = 1'b0;
        $display("burst written level=%0d ready=%0b", fifo_level, tx_ready);
        check("level_full", fifo_level, 4);
        check("ready_full", tx_ready, 1'b0);

        wait_request("request_11");
        d0 = done_cnt;
        e0 = err_cnt;
        t  = 0;
        while (t < 700 && error !== 1'b1) begin
            @(negedge clock);
            t++;
        end
        $display("timeout after %0d cycles", t);
        check("timeout_error_pulse", error, 1'b1);
        check("timeout_window", (t >= 465 && t <= 492), 1'b1);
        check("timeout_lines_released", {device_clock_out, device_data_out}, 2'b11);
        @(negedge clock);
        check("timeout_error_once", err_cnt, e0 + 1);
        check("timeout_no_done", done_cnt, d0);
        wait_inhibit("next_byte_starts");
        check("level_after_timeout", fifo_level, 3);

        wait_request("request_22");
        for (int k = 0; k < 20 && device_clock_out === 1'b0; k++) @(negedge clock);
        for (int i = 0; i < 4; i++) dev_bit(1'b1, bits[i]);
        check("bit3_of_22", device_data_out, 1'b0);
        #2 reset = 1'b1;
        #1;
        $display("reset mid-frame lines=%02b", {device_clock_out, device_data_out});
        check("reset_lines_immediate", {device_clock_out, device_data_out}, 2'b11);
        @(negedge clock);
        check("reset_level", fifo_level, 0);
        check("reset_busy", busy, 1'b0);
        check("reset_ready", tx_ready, 1'b1);
        reset = 1'b0;
        @(negedge clock);

        sum0 = done_cnt + err_cnt;
        push(8'h5A);
        run_frame(1'b0, bits, inh);
        $display("frame data=5a bits=%03h", bits);
        check("bits_5a_after_reset", bits, 10'h35A);
        wait_result(sum0);
        check("done_count_final", done_cnt, exp_done + 1);
        check("error_count_final", err_cnt, exp_err + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
